// File: rtl/dallanma_ongorucu.sv
// Fetch-side branch predictor: bimodal 2-bit counters with a direct-mapped BTB.
// The table is cleared one entry per cycle after reset or a flush request.
module dallanma_ongorucu #(
    parameter int PS_BIT     = 32,
    parameter int SATIR      = 64,
    localparam int IDX_BIT    = $clog2(SATIR),
    localparam int ETIKET_BIT = PS_BIT - IDX_BIT - 2
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              temizle_i,
    output logic              hazir_o,
    input  logic [PS_BIT-1:0] cek_ps_i,
    input  logic              cek_ps_gecerli_i,
    output logic              tahmin_gecerli_o,
    output logic              tahmin_atladi_o,
    output logic [PS_BIT-1:0] tahmin_hedef_o,
    input  logic [PS_BIT-1:0] g2_ps_i,
    input  logic [PS_BIT-1:0] g2_hedef_i,
    input  logic              g2_guncelle_i,
    input  logic              g2_atladi_i,
    input  logic              g2_hatali_tahmin_i,
    output logic [31:0]       sayac_guncelle_o,
    output logic [31:0]       sayac_hatali_o
);

    typedef enum logic {TEMIZLE, HAZIR} durum_t;

    durum_t               durum_reg;
    logic [IDX_BIT-1:0]   temizle_idx_reg;

    logic                  gecerli_reg [SATIR];
    logic [ETIKET_BIT-1:0] etiket_reg  [SATIR];
    logic [PS_BIT-1:0]     hedef_reg   [SATIR];
    logic [1:0]            sayac_reg   [SATIR];

    logic [IDX_BIT-1:0]    sorgu_idx, g2_idx;
    logic [ETIKET_BIT-1:0] sorgu_etiket, g2_etiket;
    logic                  sorgu_isabet, g2_isabet;
    logic [1:0]            sayac_next;
    logic                  unused_dusuk_bitler;

    assign sorgu_idx    = cek_ps_i[IDX_BIT+1:2];
    assign sorgu_etiket = cek_ps_i[PS_BIT-1:IDX_BIT+2];
    assign g2_idx       = g2_ps_i[IDX_BIT+1:2];
    assign g2_etiket    = g2_ps_i[PS_BIT-1:IDX_BIT+2];
    assign unused_dusuk_bitler = ^{cek_ps_i[1:0], g2_ps_i[1:0]};

    assign hazir_o = (durum_reg == HAZIR);

    // Query reads the registered table directly, so a same-cycle update is not bypassed.
    assign sorgu_isabet     = gecerli_reg[sorgu_idx] && (etiket_reg[sorgu_idx] == sorgu_etiket);
    assign tahmin_gecerli_o = hazir_o && cek_ps_gecerli_i && sorgu_isabet;
    assign tahmin_atladi_o  = tahmin_gecerli_o && sayac_reg[sorgu_idx][1];
    assign tahmin_hedef_o   = tahmin_gecerli_o ? hedef_reg[sorgu_idx] : '0;

    always_comb begin
        g2_isabet  = gecerli_reg[g2_idx] && (etiket_reg[g2_idx] == g2_etiket);
        sayac_next = sayac_reg[g2_idx];
        if (g2_atladi_i) begin
            if (sayac_reg[g2_idx] != 2'd3) sayac_next = sayac_reg[g2_idx] + 2'd1;
        end else begin
            if (sayac_reg[g2_idx] != 2'd0) sayac_next = sayac_reg[g2_idx] - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            durum_reg       <= TEMIZLE;
            temizle_idx_reg <= '0;
        end else begin
            case (durum_reg)
                TEMIZLE: begin
                    if (temizle_i) begin
                        temizle_idx_reg <= '0;
                    end else begin
                        temizle_idx_reg <= temizle_idx_reg + 1'b1;
                        if (temizle_idx_reg == IDX_BIT'(SATIR - 1)) durum_reg <= HAZIR;
                    end
                end
                HAZIR: begin
                    if (temizle_i) begin
                        durum_reg       <= TEMIZLE;
                        temizle_idx_reg <= '0;
                    end
                end
                default: durum_reg <= TEMIZLE;
            endcase
        end
    end

    // Table storage carries no reset; the clear sweep establishes its contents.
    always_ff @(posedge clk_i) begin
        if (rstn_i && durum_reg == TEMIZLE && !temizle_i) begin
            gecerli_reg[temizle_idx_reg] <= 1'b0;
            sayac_reg[temizle_idx_reg]   <= 2'd1;
        end else if (rstn_i && durum_reg == HAZIR && g2_guncelle_i) begin
            if (g2_isabet) begin
                sayac_reg[g2_idx] <= sayac_next;
                if (g2_atladi_i) hedef_reg[g2_idx] <= g2_hedef_i;
            end else if (g2_atladi_i) begin
                gecerli_reg[g2_idx] <= 1'b1;
                etiket_reg[g2_idx]  <= g2_etiket;
                hedef_reg[g2_idx]   <= g2_hedef_i;
                sayac_reg[g2_idx]   <= 2'd2;
            end
        end
    end

    // Saturating statistics: [0] accepted updates, [1] mispredicted updates.
    logic [31:0] istat_reg [2];
    logic [1:0]  istat_olay;

    assign istat_olay = {g2_guncelle_i && g2_hatali_tahmin_i, g2_guncelle_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_istat
            always_ff @(posedge clk_i) begin
                if (!rstn_i) begin
                    istat_reg[gi] <= '0;
                end else if (istat_olay[gi] && istat_reg[gi] != 32'hFFFF_FFFF) begin
                    istat_reg[gi] <= istat_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign sayac_guncelle_o = istat_reg[0];
    assign sayac_hatali_o   = istat_reg[1];

endmodule
